// File: rtl/hex_display_ctrl_pkg.sv
// Shared types and constants for the sequenced six-digit hex display controller.
package hex_disp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Active-low segment pattern with every segment off.
    localparam logic [6:0] BLANK_SEG = 7'b1111111;

    // Number of displays on the board, one nibble per display.
    localparam int DEF_NUM_DIGITS = 6;

endpackage

// File: rtl/hex_to_7.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Segment order is {g,f,e,d,c,b,a}; a 0 bit lights the segment.
module hex_to_7 (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Full 16-entry lookup, upper/lower case chosen to keep b and d distinct from 8 and 0.
    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Sequenced display controller: latches a value on load, then walks the
// nibbles most-significant first through a single shared decoder, writing
// one registered HEX output per clock. Supports per-digit blanking and
// leading-zero suppression (digit 0 is always shown).
module hex_display_ctrl
    import hex_disp_pkg::*;
#(
    parameter int         NUM_DIGITS = DEF_NUM_DIGITS,
    parameter logic [6:0] BLANK      = BLANK_SEG
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    lz_en,
    input  logic                    load,
    output logic                    busy,
    output logic                    done,
    output logic [6:0]              HEX0,
    output logic [6:0]              HEX1,
    output logic [6:0]              HEX2,
    output logic [6:0]              HEX3,
    output logic [6:0]              HEX4,
    output logic [6:0]              HEX5
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic                    seen_nz;
    logic [4*NUM_DIGITS-1:0] val_q;
    logic [NUM_DIGITS-1:0]   mask_q;
    logic                    lz_q;
    logic [6:0]              hex_q [NUM_DIGITS];

    logic [IDX_W+1:0]        bitpos;
    logic [3:0]              nib;
    logic [6:0]              dec_seg;
    logic [6:0]              digit_seg;

    assign bitpos = {idx, 2'b00};
    assign nib    = val_q[bitpos +: 4];

    hex_to_7 u_dec (
        .nibble (nib),
        .seg    (dec_seg)
    );

    // Pick what the current digit shows: mask wins, then leading-zero blanking, then the glyph.
    always_comb begin
        digit_seg = dec_seg;
        if (mask_q[idx]) begin
            digit_seg = BLANK;
        end else if (lz_q && !seen_nz && (nib == 4'h0) && (idx != '0)) begin
            digit_seg = BLANK;
        end
    end

    // Control FSM, digit index walk and registered segment outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= LAST_IDX;
            seen_nz <= 1'b0;
            val_q   <= '0;
            mask_q  <= '0;
            lz_q    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                hex_q[i] <= BLANK;
            end
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        val_q   <= value;
                        mask_q  <= blank_mask;
                        lz_q    <= lz_en;
                        idx     <= LAST_IDX;
                        seen_nz <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    hex_q[idx] <= digit_seg;
                    // A masked nonzero digit still counts as significant.
                    seen_nz    <= seen_nz | (nib != 4'h0);
                    if (idx == '0) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: table of full scans plus hand-written
// sequences for held load, mid-scan reset and per-edge digit updates.
module tb_hex_display_ctrl;

    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S8 = 7'b0000000;

    logic        clk;
    logic        reset;
    logic [23:0] value;
    logic [5:0]  blank_mask;
    logic        lz_en;
    logic        load;
    logic        busy;
    logic        done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int ncmp;
    int nfail;

    typedef struct {
        string       name;
        logic [23:0] value;
        logic [5:0]  mask;
        logic        lz;
        logic [41:0] exp;   // {HEX5,HEX4,HEX3,HEX2,HEX1,HEX0}
    } vec_t;

    vec_t vecs [8];

    hex_display_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .value      (value),
        .blank_mask (blank_mask),
        .lz_en      (lz_en),
        .load       (load),
        .busy       (busy),
        .done       (done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [41:0] hexbus();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic chk(input string name, input logic [41:0] act, input logic [41:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Pulse load for one edge (edge k) and leave the bench at the negedge after edge k.
    task automatic start_load(input logic [23:0] v, input logic [5:0] m, input logic lz);
        @(negedge clk);
        value      = v;
        blank_mask = m;
        lz_en      = lz;
        load       = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
    endtask

    // Full scan with timing checks on busy/done and a final display check.
    task automatic run_vec(input string name, input logic [23:0] v, input logic [5:0] m,
                           input logic lz, input logic [41:0] exp);
        start_load(v, m, lz);
        chk({name, " busy after k"}, 42'(busy), 42'd1);
        // Inputs changed mid-scan must not matter.
        value      = ~v;
        blank_mask = ~m;
        lz_en      = ~lz;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j < 6) chk({name, " done early"}, 42'(done), 42'd0);
        end
        chk({name, " done at k+6"}, 42'(done), 42'd1);
        chk({name, " busy at k+6"}, 42'(busy), 42'd1);
        chk({name, " display"}, hexbus(), exp);
        @(posedge clk);
        @(negedge clk);
        chk({name, " done off k+7"}, 42'(done), 42'd0);
        chk({name, " busy off k+7"}, 42'(busy), 42'd0);
    endtask

    initial begin
        logic [41:0] exp6;
        logic [6:0]  fed [6];
        int          dcount;

        ncmp       = 0;
        nfail      = 0;
        reset      = 1'b1;
        value      = '0;
        blank_mask = '0;
        lz_en      = 1'b0;
        load       = 1'b0;

        vecs[0] = '{"t1_00A3F1_lz", 24'h00A3F1, 6'b000000, 1'b1,
                    {B, B, 7'b0001000, 7'b0110000, 7'b0001110, 7'b1111001}};
        vecs[1] = '{"t2_zero_lz", 24'h000000, 6'b000000, 1'b1, {B, B, B, B, B, S0}};
        vecs[2] = '{"t2_zero_nolz", 24'h000000, 6'b000000, 1'b0, {S0, S0, S0, S0, S0, S0}};
        vecs[3] = '{"t3_123456_mask", 24'h123456, 6'b100010, 1'b0,
                    {B, 7'b0100100, 7'b0110000, 7'b0011001, B, 7'b0000010}};
        vecs[4] = '{"masked_nz_sets_seen", 24'h100000, 6'b100000, 1'b1,
                    {B, S0, S0, S0, S0, S0}};
        vecs[5] = '{"inner_zero_lz", 24'h000102, 6'b000000, 1'b1,
                    {B, B, B, 7'b1111001, S0, 7'b0100100}};
        vecs[6] = '{"mask_over_digit0", 24'h000000, 6'b000001, 1'b1, {B, B, B, B, B, B}};
        vecs[7] = '{"all_eights", 24'h888888, 6'b000000, 1'b0, {S8, S8, S8, S8, S8, S8}};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset hex", hexbus(), {B, B, B, B, B, B});
        chk("reset busy", 42'(busy), 42'd0);
        chk("reset done", 42'(done), 42'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle busy", 42'(busy), 42'd0);

        // Table-driven scans
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].name, vecs[i].value, vecs[i].mask, vecs[i].lz, vecs[i].exp);
        end

        // Per-edge update with display pre-loaded to all 8s (last table entry)
        fed[0] = 7'b0001110; fed[1] = 7'b0000110; fed[2] = 7'b0100001;
        fed[3] = 7'b1000110; fed[4] = 7'b0000011; fed[5] = 7'b0001000;
        exp6 = {S8, S8, S8, S8, S8, S8};
        start_load(24'hFEDCBA, 6'b000000, 1'b0);
        chk("t6 no write at k", hexbus(), exp6);
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            @(negedge clk);
            exp6[7*(6-j) +: 7] = fed[j-1];
            chk($sformatf("t6 edge k+%0d", j), hexbus(), exp6);
        end
        chk("t6 done", 42'(done), 42'd1);
        @(posedge clk);
        @(negedge clk);

        // Load held high through a scan, with a different value presented
        @(negedge clk);
        value      = 24'h00A3F1;
        blank_mask = 6'b000000;
        lz_en      = 1'b1;
        load       = 1'b1;
        @(posedge clk);           // edge k
        @(negedge clk);
        value  = 24'h123456;
        lz_en  = 1'b0;
        dcount = 0;
        for (int j = 1; j <= 7; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dcount++;
            if (j == 6) chk("t4 first result", hexbus(), vecs[0].exp);
        end
        chk("t4 single done", 42'(dcount), 42'd1);
        chk("t4 busy low k+7", 42'(busy), 42'd0);
        @(posedge clk);           // edge k+8: first edge with busy=0 and load=1
        @(negedge clk);
        chk("t4 restart k+8", 42'(busy), 42'd1);
        load = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("t4 second done", 42'(done), 42'd1);
        chk("t4 second result", hexbus(), {7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010});
        @(posedge clk);
        @(negedge clk);

        // Reset at edge k+3 of a scan
        start_load(24'h123456, 6'b000000, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t5 HEX5 written before reset", 42'(HEX5), 42'(7'b1111001));
        reset = 1'b1;
        #1;
        chk("t5 async blank", hexbus(), {B, B, B, B, B, B});
        chk("t5 async busy", 42'(busy), 42'd0);
        chk("t5 async done", 42'(done), 42'd0);
        @(negedge clk);
        reset  = 1'b0;
        dcount = 0;
        for (int j = 0; j < 8; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) dcount++;
        end
        chk("t5 no done after abort", 42'(dcount), 42'd0);
        run_vec("t5 reload", 24'h00A3F1, 6'b000000, 1'b1, vecs[0].exp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
